sensor_debounce: RTL
====================

# sensor_debounce

Conditioning stage directly upstream of the genetic filter: samples a raw, noisy sensor line, synchronises it, and presents a clean, debounced `Sensor` level for the filter's `Sensor` input. A debounced level change requires `STABLE` consecutive equal samples. The block also emits a one-cycle rising-edge strobe and keeps a saturating count of debounced rising edges, used by benches and monitors to check the filter's response sequence.

## Interface
Parameters:
- `STABLE`, 4: consecutive equal samples required to change `Sensor`. Legal range 2..2^`CNT_W`−1.
- `CNT_W`, 8: width of the internal stability counter.
- `EDGE_W`, 8: width of `EdgeCount`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `Raw`, input, 1: undebounced sensor line, asynchronous to `clk`.
- `Clear`, input, 1: synchronous clear of `EdgeCount`.
- `Sensor`, output, 1: debounced level; feeds the filter's `Sensor`.
- `SensorRise`, output, 1: one-cycle strobe on each debounced 0→1 transition.
- `EdgeCount`, output, `EDGE_W`: saturating count of debounced rising edges.

## Operation
- Sample path: `Raw` → optional 2-flop synchroniser (see Configuration) → `s`. The FSM samples `s` on every clock edge.
- The FSM has four states: `S_LOW`, `S_RISE`, `S_HIGH` and `S_FALL`. `cnt` is `CNT_W` bits wide.
  - `S_LOW`: if `s=1`, go to `S_RISE` with `cnt=1`. Otherwise stay.
  - `S_RISE`: if `s=0`, go to `S_LOW` with `cnt=0`.
    - If `s=1` and `cnt==STABLE-1`, go to `S_HIGH`, set `Sensor<=1`, `SensorRise<=1`, `cnt=0`.
    - If `s=1` otherwise, `cnt++`.
  - `S_HIGH`: if `s=0`, go to `S_FALL` with `cnt=1`. Otherwise stay.
  - `S_FALL`: if `s=1`, go to `S_HIGH` with `cnt=0`.
    - If `s=0` and `cnt==STABLE-1`, go to `S_LOW`, set `Sensor<=0`, `cnt=0`.
    - If `s=0` otherwise, `cnt++`.
- `Sensor` is registered and changes only on the `S_RISE`→`S_HIGH` and `S_FALL`→`S_LOW` transitions. Any run shorter than `STABLE` samples is discarded with no output effect.
- `SensorRise` is high for exactly the one cycle after the edge where `Sensor` goes 0→1. There is no falling strobe.
- `EdgeCount`:
  - Increments on each `SensorRise` cycle.
  - Saturates at 2^`EDGE_W`−1 and never wraps.
  - `Clear=1` forces 0 on the next edge.
  - If `Clear` and an increment coincide, `Clear` wins and the result is 0; that edge is not counted.
- Reset (`rst_n=0`, at any time, including mid-count):
  - State goes to `S_LOW`, `cnt=0`, synchroniser flops to 0.
  - `Sensor=0`, `SensorRise=0`, `EdgeCount=0`, asynchronously.
  - After release, `Raw` held at 1 is treated as a fresh rise needing the full latency.

## Timing
- Let E0 be the first clock edge at which a new `Raw` level is stable at the input.
- With the synchroniser: `Sensor` updates at edge E0+`STABLE`+1. Latency is `STABLE`+2 edges counting E0, i.e. 2 synchroniser cycles + `STABLE`.
- Without the synchroniser: `Sensor` updates at edge E0+`STABLE`−1.
- `SensorRise` asserts at the same edge as `Sensor` 0→1 and deasserts on the next edge.
- `EdgeCount` reflects a rise one edge after `SensorRise` is sampled high, i.e. it updates at the edge following `SensorRise` assertion.
- Sustained `Raw` toggling with period < `STABLE` cycles: `Sensor` never changes and `EdgeCount` is constant.

## Configuration
- `SENSOR_DEBOUNCE_SYNC_EN` defined: a 2-flop synchroniser sits on `Raw`; latencies are as above, with the +2.
- Macro undefined: `s=Raw` directly, with no synchroniser flops. This is for benches and synthesis flows where `Raw` is already synchronous to `clk`. FSM behaviour is otherwise identical; latency is 2 cycles shorter.

## Test plan
- Reset, then `Raw` 0→1 held, with `STABLE=4` and the sync macro defined: `Sensor` and `SensorRise` go high at E0+5. `SensorRise` is low at E0+6. `EdgeCount`=1.
- `Raw` glitch high for 3 cycles with `STABLE=4`: `Sensor` stays 0, `SensorRise` never pulses, `EdgeCount` stays 0.
- `Sensor`=1, then `Raw` drops for 2 cycles and returns high: `Sensor` stays 1. A subsequent clean drop gives `Sensor`=0 at E0+5 with no strobe.
- 260 clean rise/fall pulses with `EDGE_W=8`: `EdgeCount` stops at 255. `Clear` coinciding with a rise gives `EdgeCount`=0.
- `rst_n` asserted while in `S_RISE` with `cnt`=3: all outputs go to 0 immediately. After release, with `Raw` still 1, `Sensor` rises at E0+5 measured from the first post-reset edge.
- Macro undefined, `STABLE=4`: `Raw` 0→1 gives `Sensor`=1 at E0+3.

Source files
------------

// File: rtl/sensor_debounce.sv
// sensor_debounce: conditions a raw, noisy sensor line into a clean debounced level.
//
// A level change on the output needs STABLE consecutive equal samples of the
// sampled line. A one-cycle strobe marks each debounced rising edge, and a
// saturating counter keeps the number of debounced rising edges.
//
// Build option:
//   SENSOR_DEBOUNCE_SYNC_EN  - when defined, Raw passes through a 2-flop
//                              synchroniser before the debounce FSM (+2 cycles
//                              of latency). When undefined, Raw is sampled
//                              directly and must already be synchronous to clk.
module sensor_debounce #(
  parameter int unsigned STABLE = 4,  // legal range 2 .. 2**CNT_W-1
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned EDGE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Raw,
  input  logic              Clear,
  output logic              Sensor,
  output logic              SensorRise,
  output logic [EDGE_W-1:0] EdgeCount
);

  typedef enum logic [1:0] {
    StLow  = 2'd0,
    StRise = 2'd1,
    StHigh = 2'd2,
    StFall = 2'd3
  } state_e;

  // Value of the stability counter on the sample that completes a run.
  localparam logic [CNT_W-1:0]  CntLast = CNT_W'(STABLE - 1);
  localparam logic [EDGE_W-1:0] EdgeMax = {EDGE_W{1'b1}};

  logic s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sensor_q, sensor_d;
  logic              rise_q, rise_d;
  logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;

  // ---------------------------------------------------------------------------
  // Sample path
  // ---------------------------------------------------------------------------
`ifdef SENSOR_DEBOUNCE_SYNC_EN
  logic sync1_q, sync2_q;

  // Two-flop synchroniser for the asynchronous Raw line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= Raw;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  // Raw is already synchronous to clk in this build.
  assign s = Raw;
`endif

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------

  // State, run counter, debounced level and rise strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StLow;
      cnt_q    <= '0;
      sensor_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sensor_q <= sensor_d;
      rise_q   <= rise_d;
    end
  end

  // Next-state logic: count a run of samples opposite to the current level and
  // commit the new level only when the run reaches STABLE samples.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sensor_d = sensor_q;
    rise_d   = 1'b0;

    unique case (state_q)
      StLow: begin
        if (s) begin
          state_d = StRise;
          cnt_d   = CNT_W'(1);
        end
      end

      StRise: begin
        if (!s) begin
          // Run broken before reaching STABLE: discard it.
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d  = StHigh;
          sensor_d = 1'b1;
          rise_d   = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      StHigh: begin
        if (!s) begin
          state_d = StFall;
          cnt_d   = CNT_W'(1);
        end
      end

      StFall: begin
        if (s) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          // No strobe on the falling side.
          state_d  = StLow;
          sensor_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Rising-edge counter
  // ---------------------------------------------------------------------------

  // Next count: Clear has priority over an increment; saturate at all-ones.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (Clear) begin
      edge_cnt_d = '0;
    end else if (rise_q && (edge_cnt_q != EdgeMax)) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  // Edge counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt_q <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign Sensor     = sensor_q;
  assign SensorRise = rise_q;
  assign EdgeCount  = edge_cnt_q;

endmodule
